adc_moving_avg: RTL and testbench
=================================

ADC_MOVING_AVG -- requirements
Module: adc_moving_avg

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width (two's complement, matches the MCP3910 channel word).
REQ-002 SHALL have parameter LOG2_N, default 4, log2 of window length N (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock (SPI-domain clock); reset is asynchronous and active-low.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_data  input  DATA_W  raw ADC sample from the MCP3910 controller.
REQ-006 SHALL have port in_valid  input  1  one-cycle strobe, new sample present.
REQ-007 SHALL have port clear  input  1  synchronous flush of window and state.
REQ-008 SHALL have port out_data  output  DATA_W  windowed average, feeds the battery display.
REQ-009 SHALL have port out_valid  output  1  one-cycle strobe, out_data updated.
REQ-010 SHALL have port filled  output  1  high once N samples are held in the window.

Function
REQ-011 SHALL hold the last N accepted samples in a circular buffer with write pointer wrapping N-1 -> 0.
REQ-012 SHALL keep signed running sum of width DATA_W+LOG2_N, updated per accepted sample as sum + new - oldest; no overflow possible.
REQ-013 SHALL implement states FILL and RUN; reset/clear enters FILL with count 0.
REQ-014 In FILL: each in_valid writes sample, adds to sum (oldest treated as 0), increments count; Nth sample moves to RUN.
REQ-015 In RUN: each in_valid overwrites oldest entry, sum updated with subtraction of evicted sample.
REQ-016 out_valid SHALL pulse exactly one cycle after every in_valid accepted in RUN and after the Nth sample in FILL; never during FILL otherwise.
REQ-017 out_data SHALL equal sum arithmetically shifted right by LOG2_N (floor toward minus infinity), including the sample accepted that cycle; held between pulses.
REQ-018 filled SHALL be high in RUN, low in FILL.
REQ-019 clear and in_valid in the same cycle: clear wins, sample discarded, no out_valid.
REQ-020 Back-to-back in_valid on consecutive cycles SHALL each be accepted (throughput 1 sample/cycle).

Reset
REQ-021 rst_n low SHALL asynchronously force state FILL, count 0, pointer 0, sum 0, out_data 0, out_valid 0, filled 0; buffer contents need not reset.
REQ-022 Reset or clear mid-window SHALL discard all partial data; first out_valid after release needs N fresh samples.

Configuration
REQ-023 With ADC_AVG_PEAK_EN defined, SHALL add outputs peak_max and peak_min (DATA_W) tracking extreme out_data values since reset/clear, updated with out_valid; reset to 0x800000-style minimum for max and maximum for min before first output, taking first out_data directly.
REQ-024 Without ADC_AVG_PEAK_EN, those ports and their registers SHALL not exist.

Structure
REQ-025 SHALL place state enum (FILL, RUN) and default width constants in shared package adc_pkg.
REQ-026 SHALL instantiate one sub-module, avg_ring_buf: N x DATA_W circular storage with write pointer and read-oldest port.

Verification
REQ-027 LOG2_N=2: feed 4,8,12,16 -> no out_valid for first three; after 16 out_valid, out_data=10, filled=1.
REQ-028 Continue with 20 -> out_data=14 one cycle later; then 0,0,0,0 -> final out_data=0.
REQ-029 Negative rounding: -1,-1,-1,-2 -> sum -5, out_data=-2 (0xFFFFFE).
REQ-030 Full scale: four 0x7FFFFF -> 0x7FFFFF; four 0x800000 -> 0x800000, no wrap.
REQ-031 clear asserted with 3rd sample of fill -> filled=0, next out_valid only after 4 more samples, value = their average.
REQ-032 rst_n pulsed low mid-RUN asynchronously (between clock edges) -> all outputs 0 immediately; ADC_AVG_PEAK_EN build: inputs 5,-3 averages track peak_max/peak_min correctly.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state type and default widths for the ADC moving average
package adc_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_LOG2_N = 4;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_e;

endpackage

// File: rtl/avg_ring_buf.sv
// rtl/avg_ring_buf.sv - N x DATA_W circular sample store with write pointer and oldest-entry read
module avg_ring_buf
  import adc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_oldest,
  output logic [LOG2_N-1:0] wr_ptr
);

  localparam int N = 1 << LOG2_N;

  logic [DATA_W-1:0] mem [N];

  // The slot about to be overwritten is the oldest sample once the window is full.
  assign rd_oldest = mem[wr_ptr];

  // Write pointer wraps N-1 -> 0 naturally because N is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Sample storage needs no reset; stale slots are masked by the FILL state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/adc_moving_avg.sv
// rtl/adc_moving_avg.sv - windowed moving average of ADC samples; optional peak tracking via ADC_AVG_PEAK_EN
module adc_moving_avg
  import adc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef ADC_AVG_PEAK_EN
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
`endif
  output logic              filled
);

  localparam int SUM_W = DATA_W + LOG2_N;

  avg_state_e        state_q, state_d;
  logic [LOG2_N-1:0] count_q, count_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  in_ext, oldest_ext;
  logic [DATA_W-1:0] oldest;
  logic [DATA_W-1:0] avg_d;
  logic [LOG2_N-1:0] wr_ptr;
  logic              accept;
  logic              emit;

  assign accept = in_valid & ~clear;
  assign in_ext = {{LOG2_N{in_data[DATA_W-1]}}, in_data};
  // Upper DATA_W bits of the sum are the arithmetic shift right by LOG2_N (floor).
  assign avg_d  = sum_d[SUM_W-1 -: DATA_W];
  assign filled = (state_q == RUN);

  avg_ring_buf #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .wr_en     (accept),
    .wr_data   (in_data),
    .rd_oldest (oldest),
    .wr_ptr    (wr_ptr)
  );

  // Next state, running sum and output strobe; clear outranks a coincident sample.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sum_d      = sum_q;
    emit       = 1'b0;
    oldest_ext = '0;
    if (state_q == RUN) begin
      oldest_ext = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
    end
    if (clear) begin
      state_d = FILL;
      count_d = '0;
      sum_d   = '0;
    end else if (in_valid) begin
      sum_d = sum_q + in_ext - oldest_ext;
      case (state_q)
        FILL: begin
          count_d = count_q + 1'b1;
          if (count_q == '1) begin
            state_d = RUN;
            emit    = 1'b1;
          end
        end
        RUN:     emit = 1'b1;
        default: state_d = FILL;
      endcase
    end
  end

  // State, sum and registered average; out_data holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      count_q   <= '0;
      sum_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      out_valid <= emit;
      if (clear) begin
        out_data <= '0;
      end else if (emit) begin
        out_data <= avg_d;
      end
    end
  end

`ifdef ADC_AVG_PEAK_EN
  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX = ~S_MIN;

  // Extremes start at the opposite rails so the first average is taken as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_max <= S_MIN;
      peak_min <= S_MAX;
    end else if (clear) begin
      peak_max <= S_MIN;
      peak_min <= S_MAX;
    end else if (emit) begin
      if ($signed(avg_d) > $signed(peak_max)) peak_max <= avg_d;
      if ($signed(avg_d) < $signed(peak_min)) peak_min <= avg_d;
    end
  end
`endif

endmodule

// File: tb/tb_adc_moving_avg.sv
// tb/tb_adc_moving_avg.sv - directed self-checking bench for adc_moving_avg with LOG2_N=2
module tb_adc_moving_avg;

  localparam int DATA_W = 24;
  localparam int LOG2_N = 2;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              clear;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              filled;
`ifdef ADC_AVG_PEAK_EN
  logic [DATA_W-1:0] peak_max;
  logic [DATA_W-1:0] peak_min;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  adc_moving_avg #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef ADC_AVG_PEAK_EN
    .peak_max  (peak_max),
    .peak_min  (peak_min),
`endif
    .filled    (filled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one sample for one clock edge; outputs are observed #1 after that edge.
  task automatic push(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_filled", 32'(filled), 32'h0);
    rst_n = 1'b1;
    idle();

    // Fill window: 4,8,12,16 -> average 10
    push(24'd4);
    check("fill1_valid", 32'(out_valid), 32'h0);
    push(24'd8);
    check("fill2_valid", 32'(out_valid), 32'h0);
    push(24'd12);
    check("fill3_valid", 32'(out_valid), 32'h0);
    check("fill3_filled", 32'(filled), 32'h0);
    push(24'd16);
    check("fill4_valid", 32'(out_valid), 32'h1);
    check("fill4_data", 32'(out_data), 32'd10);
    check("fill4_filled", 32'(filled), 32'h1);
    idle();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_hold", 32'(out_data), 32'd10);

    // Sliding: 20 -> 14, then zeros -> 12, 9, 5, 0 (back-to-back)
    push(24'd20);
    check("run20_valid", 32'(out_valid), 32'h1);
    check("run20_data", 32'(out_data), 32'd14);
    push(24'd0);
    check("run0a_data", 32'(out_data), 32'd12);
    push(24'd0);
    check("run0b_data", 32'(out_data), 32'd9);
    push(24'd0);
    check("run0c_data", 32'(out_data), 32'd5);
    push(24'd0);
    check("run0d_valid", 32'(out_valid), 32'h1);
    check("run0d_data", 32'(out_data), 32'd0);

    // Negative floor rounding: sum -5 -> -2
    do_clear();
    check("clr_filled", 32'(filled), 32'h0);
    push(24'hFFFFFF);
    push(24'hFFFFFF);
    push(24'hFFFFFF);
    check("neg3_valid", 32'(out_valid), 32'h0);
    push(24'hFFFFFE);
    check("neg_valid", 32'(out_valid), 32'h1);
    check("neg_data", 32'(out_data), 32'h00FFFFFE);

    // Full scale both rails
    do_clear();
    for (int i = 0; i < 4; i++) push(24'h7FFFFF);
    check("fs_pos", 32'(out_data), 32'h007FFFFF);
    for (int i = 0; i < 4; i++) push(24'h800000);
    check("fs_neg", 32'(out_data), 32'h00800000);

    // Clear coinciding with third fill sample discards everything
    do_clear();
    push(24'd1);
    push(24'd2);
    in_data  = 24'd99;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clrwin_valid", 32'(out_valid), 32'h0);
    check("clrwin_filled", 32'(filled), 32'h0);
    push(24'd100);
    push(24'd200);
    push(24'd300);
    check("refill3_valid", 32'(out_valid), 32'h0);
    push(24'd400);
    check("refill4_valid", 32'(out_valid), 32'h1);
    check("refill4_data", 32'(out_data), 32'd250);

    // Asynchronous reset between clock edges while in RUN
    push(24'd500);
    check("pre_rst_data", 32'(out_data), 32'd350);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_data", 32'(out_data), 32'h0);
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_filled", 32'(filled), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    push(24'd8);
    push(24'd8);
    push(24'd8);
    check("post_rst_valid", 32'(out_valid), 32'h0);
    push(24'd8);
    check("post_rst_data", 32'(out_data), 32'd8);

`ifdef ADC_AVG_PEAK_EN
    do_clear();
    check("pk_init_max", 32'(peak_max), 32'h00800000);
    check("pk_init_min", 32'(peak_min), 32'h007FFFFF);
    for (int i = 0; i < 4; i++) push(24'd5);
    check("pk_first_max", 32'(peak_max), 32'd5);
    check("pk_first_min", 32'(peak_min), 32'd5);
    // Averages 3, 1, -1, -3
    for (int i = 0; i < 4; i++) push(24'hFFFFFD);
    check("pk_avg_last", 32'(out_data), 32'h00FFFFFD);
    check("pk_max", 32'(peak_max), 32'd5);
    check("pk_min", 32'(peak_min), 32'h00FFFFFD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
